rs_operand_fetch: RTL
=====================

// Module: rs_operand_fetch
// PURPOSE
//  Reservation station that is the requesting end of the PRF read protocol. It holds
//  renamed uops and tracks each source tag. For a tag whose value already sits in the PRF,
//  it issues a requesting/requested_id read. It captures operand values from the shared
//  CDB, whether the broadcast is a PRF read response or an FU result.
//  When both operands of an entry are captured, it dispatches the uop to its FU.
// PARAMETERS
//  RS_DEPTH      4   number of entries
//  PRF_SIZE      16  physical registers; tags are 4 bits
//  RETRY_CYCLES  7   cycles to wait for a read response before re-requesting
// PORTS
//  clk                  in   1         clock
//  rst                  in   1         synchronous, active-low reset (rst==0 resets)
//  alloc_valid          in   1         rename presents a uop
//  alloc_ready          out  1         a free entry exists
//  alloc_op             in   3         FU opcode
//  alloc_src1/2         in   4 each    source physical tags
//  alloc_dst            in   4         destination physical tag
//  ready_regs           in   PRF_SIZE  PRF per-register ready bits
//  requesting           out  1         PRF read request (one-cycle pulse)
//  requested_id         out  4         tag being read; 0 when not requesting
//  shared_cdb_transmit  in   1         shared CDB valid
//  shared_cdb_id        in   4         shared CDB tag
//  shared_cdb_val       in   8         shared CDB value
//  issue_valid          out  1         uop with both operands ready
//  issue_ready          in   1         FU accepts
//  issue_op             out  3         opcode of the dispatched uop
//  issue_a/issue_b      out  8 each    operand values
//  issue_dst            out  4         destination tag
// BEHAVIOUR
//  - Per entry: busy, op, dst; per operand: tag, have, val[7:0]. Reset (rst==0 at posedge)
//    clears all busy/have bits, puts the FSM in IDLE, zeroes the retry counter and pending tag.
//    The reset wins over alloc, capture and issue in the same cycle.
//  - Output values after reset: alloc_ready=1, requesting=0, requested_id=0,
//    issue_valid=0, issue_* = 0.
//  - Alloc: alloc_ready = |~busy (combinational). On alloc_valid&&alloc_ready the uop is
//    written into the lowest free index with have=0 on both operands.
//    Exception: if shared_cdb_transmit is high that cycle and shared_cdb_id equals a source
//    tag, that operand is written with have=1 and val=shared_cdb_val (same-cycle bypass).
//  - Capture: every cycle, each busy entry with have=0 and tag==shared_cdb_id while
//    shared_cdb_transmit=1 sets have=1 and latches the value. All matching entries and
//    operands capture in parallel.
//  - Request FSM:
//    * IDLE: choose the first candidate operand with have=0 and ready_regs[tag]=1 that is
//      not matched by the CDB this cycle. Scan order is entry 0..N-1, src1 before src2.
//      If one is found: drive requesting=1 and requested_id=tag for this cycle only,
//      latch pend_tag, clear the counter, go to WAIT.
//    * WAIT: requesting=0; the counter increments each cycle. Return to IDLE when
//      shared_cdb_transmit and shared_cdb_id==pend_tag, or when the counter reaches
//      RETRY_CYCLES (the retry path does not raise an error).
//    * A single request is outstanding at any time. Duplicate responses are harmless:
//      capture is idempotent.
//  - Issue: select the lowest-index busy entry with both have=1. issue_* are combinational
//    from that entry. On issue_valid&&issue_ready the entry's busy bit clears at the posedge.
//    A freed index is visible to alloc only from the next cycle.
//  - Priority is by index, not age; starvation is acceptable at RS_DEPTH=4.
//  - Full: alloc_ready=0 and alloc_valid is ignored.
//  - Empty: issue_valid=0 and the FSM stays in IDLE.
//  - Alloc, capture, request and issue may all occur in one cycle without interaction.
// TESTING
//  1. Hold rst=0 for 2 cycles, then release -> alloc_ready=1, issue_valid=0, requesting=0.
//  2. ready_regs[3]=ready_regs[5]=1; alloc src1=3, src2=5, dst=9.
//     -> request id 3; CDB returns (3,0x11) -> request id 5; CDB returns (5,0x22)
//     -> issue_a=0x11, issue_b=0x22, issue_dst=9.
//  3. Alloc src1=src2=7 with CDB (7,0xAB) broadcast in the same cycle
//     -> issue_valid=1 next cycle with a=b=0xAB; no PRF request is made.
//  4. ready_regs[2]=1; request id 2 is made; no CDB response arrives
//     -> exactly RETRY_CYCLES cycles later requesting=1 again with id 2.
//  5. Fill 4 entries -> alloc_ready=0, and a 5th alloc_valid is dropped.
//     Issue entry 0 with issue_ready=1 -> alloc_ready=1 next cycle; the new uop lands in index 0.
//  6. Assert rst=0 while in WAIT with 3 busy entries
//     -> next cycle all entries free, FSM IDLE, issue_valid=0.

Source files
------------

// File: rtl/rs_operand_fetch.sv
// rs_operand_fetch: reservation station that fetches source operands from the PRF/CDB and dispatches ready uops
// Ports:
//   clk, rst (sync, active-low)
//   alloc_*_i / alloc_ready_o      uop allocation from rename
//   ready_regs_i                   PRF per-register ready bits
//   requesting_o / requested_id_o  single-outstanding PRF read request
//   shared_cdb_*_i                 shared result/read-response broadcast
//   issue_*_o / issue_ready_i      dispatch to the FU
module rs_operand_fetch #(
  parameter int RS_DEPTH = 4,
  parameter int PRF_SIZE = 16,
  parameter int RETRY_CYCLES = 7,
  localparam int TW = $clog2(PRF_SIZE),
  localparam int IW = RS_DEPTH > 1 ? $clog2(RS_DEPTH) : 1,
  localparam int CW = $clog2(RETRY_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  input  logic [2:0]          alloc_op_i,
  input  logic [TW-1:0]       alloc_src1_i,
  input  logic [TW-1:0]       alloc_src2_i,
  input  logic [TW-1:0]       alloc_dst_i,
  input  logic [PRF_SIZE-1:0] ready_regs_i,
  output logic                requesting_o,
  output logic [TW-1:0]       requested_id_o,
  input  logic                shared_cdb_transmit_i,
  input  logic [TW-1:0]       shared_cdb_id_i,
  input  logic [7:0]          shared_cdb_val_i,
  output logic                issue_valid_o,
  input  logic                issue_ready_i,
  output logic [2:0]          issue_op_o,
  output logic [7:0]          issue_a_o,
  output logic [7:0]          issue_b_o,
  output logic [TW-1:0]       issue_dst_o
);
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] pend_q, pend_d;
  logic [RS_DEPTH-1:0] busy_q;
  logic [1:0] have_q [RS_DEPTH];
  logic [2:0] op_q [RS_DEPTH];
  logic [TW-1:0] dst_q [RS_DEPTH];
  logic [TW-1:0] tag_q [RS_DEPTH][2];
  logic [7:0] val_q [RS_DEPTH][2];
  logic [IW-1:0] alloc_idx, iss_idx;
  logic iss_hit, req_hit;
  logic [TW-1:0] req_tag;
  function automatic logic cdb_hit(input logic [TW-1:0] t);
    return shared_cdb_transmit_i && shared_cdb_id_i == t;
  endfunction
  assign alloc_ready_o = |(~busy_q);
  // Scanning from the top down lets the lowest index win every selection.
  always_comb begin
    alloc_idx = '0;
    iss_idx = '0;
    iss_hit = 1'b0;
    req_hit = 1'b0;
    req_tag = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IW'(i);
      if (busy_q[i] && &have_q[i]) begin
        iss_hit = 1'b1;
        iss_idx = IW'(i);
      end
      for (int s = 1; s >= 0; s--)
        if (busy_q[i] && !have_q[i][s] && ready_regs_i[tag_q[i][s]] && !cdb_hit(tag_q[i][s])) begin
          req_hit = 1'b1;
          req_tag = tag_q[i][s];
        end
    end
  end
  // The counter counts WAIT cycles after the request cycle, so a re-request
  // lands exactly RETRY_CYCLES cycles after the original one.
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    requesting_o = 1'b0;
    requested_id_o = '0;
    if (st_q == S_IDLE) begin
      if (req_hit) begin
        requesting_o = 1'b1;
        requested_id_o = req_tag;
        pend_d = req_tag;
        cnt_d = '0;
        st_d = S_WAIT;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cdb_hit(pend_q) || cnt_d == CW'(RETRY_CYCLES - 1)) st_d = S_IDLE;
    end
  end
  assign issue_valid_o = iss_hit;
  assign issue_op_o = iss_hit ? op_q[iss_idx] : '0;
  assign issue_a_o = iss_hit ? val_q[iss_idx][0] : '0;
  assign issue_b_o = iss_hit ? val_q[iss_idx][1] : '0;
  assign issue_dst_o = iss_hit ? dst_q[iss_idx] : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      busy_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) have_q[i] <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      for (int i = 0; i < RS_DEPTH; i++)
        for (int s = 0; s < 2; s++)
          if (busy_q[i] && !have_q[i][s] && cdb_hit(tag_q[i][s])) begin
            have_q[i][s] <= 1'b1;
            val_q[i][s] <= shared_cdb_val_i;
          end
      if (alloc_valid_i && alloc_ready_o) begin
        busy_q[alloc_idx] <= 1'b1;
        op_q[alloc_idx] <= alloc_op_i;
        dst_q[alloc_idx] <= alloc_dst_i;
        tag_q[alloc_idx][0] <= alloc_src1_i;
        tag_q[alloc_idx][1] <= alloc_src2_i;
        have_q[alloc_idx] <= {cdb_hit(alloc_src2_i), cdb_hit(alloc_src1_i)};
        val_q[alloc_idx][0] <= shared_cdb_val_i;
        val_q[alloc_idx][1] <= shared_cdb_val_i;
      end
      if (issue_valid_o && issue_ready_i) busy_q[iss_idx] <= 1'b0;
    end
  end
endmodule
